btb_update_ctrl: RTL and testbench
==================================

Name: btb_update_ctrl

Overview:
- Sequences all write traffic into the single-write-port branch target buffer.
- Accepts resolved-branch updates from two execute-stage branch units, buffers them per port, and arbitrates them round-robin onto one BTB write channel.
- Writes only when the fetch lookup does not own the BTB.
- Runs a full-table invalidate sweep on pipeline flush / context switch.

Parameters:
INDEX_BITS, 8, BTB index width; table has 2^INDEX_BITS entries; index = pc[INDEX_BITS+1:2]
QDEPTH, 4, per-port update FIFO depth; power of 2, >= 2

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous, active-HIGH reset (asserted = 1), despite the name
bu0_valid  in  1  branch unit 0 update request
bu0_ready  out  1  port 0 can accept
bu0_pc  in  32  branch PC
bu0_target  in  32  resolved target
bu0_taken  in  1  resolved direction
bu1_valid / bu1_ready / bu1_pc / bu1_target / bu1_taken  -  -  same as port 0, branch unit 1
btb_busy  in  1  fetch lookup owns BTB this cycle; no write may issue
flush_req  in  1  one-cycle pulse: start invalidate sweep
upd_valid  out  1  BTB write strobe (registered)
upd_inval  out  1  write clears valid bit instead of installing entry
upd_index  out  INDEX_BITS  BTB entry index
upd_tag  out  32-INDEX_BITS-2  tag = pc[31:INDEX_BITS+2]
upd_target  out  32  target to install
flushing  out  1  sweep in progress
flush_done  out  1  one-cycle pulse after last invalidate issued

Behaviour:
- Reset (async, rst_n=1):
  - FIFOs empty; round-robin pointer = port 0; FSM = RUN; sweep counter = 0.
  - All outputs 0, except bu0_ready and bu1_ready, which are 0 while reset is asserted and 1 in the first cycle after release.
- Reset mid-sweep aborts the sweep with no flush_done; reset mid-request drops all queued updates.
- Handshake: a transfer occurs on the edge where buX_valid & buX_ready.
  - buX_ready = FIFO X not full and FSM = RUN. It is combinational from registered state only, with no dependence on valid.
  - Accepted taken=1 requests are pushed. Accepted taken=0 requests are consumed and dropped.
- Issue, FSM in RUN and btb_busy=0:
  - Candidate ports are those with a non-empty FIFO.
  - With one candidate, pop it. With two, pop the port named by the RR pointer, then point the RR pointer at the other port.
  - The popped entry drives the upd_* registers on the same edge: upd_valid=1, upd_inval=0.
  - Minimum latency: accepted at edge E, upd_valid=1 in the cycle after edge E+1.
- btb_busy=1: no pop; upd_valid=0 next cycle; FIFOs and RR pointer hold.
- Simultaneous push and pop on the same FIFO is legal, including when full: ready reflects pre-pop occupancy, so a full FIFO still shows ready=0.
- FSM states RUN and FLUSH:
  - RUN -> FLUSH on flush_req=1. flush_req wins over any pop that cycle.
    - Both FIFOs are cleared, and the RR pointer resets to port 0.
    - Requests arriving that cycle are not accepted (ready already 0 next cycle).
    - flushing=1 from the next cycle.
  - FLUSH, each cycle with btb_busy=0: issue upd_valid=1, upd_inval=1, upd_index=counter, with upd_tag and upd_target = 0. Then counter += 1.
  - The counter stalls while btb_busy=1.
  - After issuing index 2^INDEX_BITS-1: counter wraps to 0, FSM -> RUN, flush_done=1 for one cycle, flushing=0 in the same cycle.
  - flush_req during FLUSH is ignored; the sweep is not restarted.
- Port 0 and port 1 may target the same index. Writes are applied in issue order; last issued wins.

Optional Feature:
- Macro: BTB_UPD_MERGE_EN.
- Defined: when an incoming taken request matches the index of its own FIFO's tail entry (most recent, not yet popped), it overwrites that entry instead of pushing.
  - The merge is accepted even when the FIFO is full, so ready = !full | tail-index-match.
  - No merge is performed with an entry being popped in the same cycle; that request is pushed normally.
- Undefined: every taken request pushes. Ready = !full.

Test Plan:
- Single update: after reset, bu0 pushes pc=0x0000_1040, target=0x0000_2000, taken=1, btb_busy=0 -> two edges later, exactly one cycle of upd_valid=1, upd_index=0x10, upd_tag=0x4, upd_target=0x2000, upd_inval=0.
- Arbitration: both FIFOs hold 2 entries, btb_busy=0 -> issue order bu0, bu1, bu0, bu1 on 4 consecutive cycles.
- Backpressure: btb_busy=1 held; bu1 pushes 4 taken updates -> bu1_ready=0 after the 4th, no upd_valid. Release btb_busy -> 4 writes on consecutive cycles, and bu1_ready=1 the cycle after the first pop.
- Not-taken drop: bu0 pushes taken=0 -> ready stays 1, no upd_valid ever.
- Flush: 3 entries queued, pulse flush_req -> queued entries never issue. 256 inval writes with indices 0..255, stretched by a 5-cycle btb_busy pulse mid-sweep. flush_done pulses once. Requests blocked (ready=0) throughout.
- Merge (BTB_UPD_MERGE_EN): btb_busy=1, bu0 pushes index 0x10 target 0xA, then index 0x10 target 0xB -> after release, a single write with target 0xB. Without the macro: two writes, 0xA then 0xB.

Source files
------------

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB write sequencer: two buffered update ports, round-robin issue, invalidate sweep.
// Optional tail-entry merge is enabled with `define BTB_UPD_MERGE_EN.
module btb_update_ctrl #(
   parameter int INDEX_BITS = 8,
   parameter int QDEPTH     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bu0_valid,
   output logic                  bu0_ready,
   input  logic [31:0]           bu0_pc,
   input  logic [31:0]           bu0_target,
   input  logic                  bu0_taken,
   input  logic                  bu1_valid,
   output logic                  bu1_ready,
   input  logic [31:0]           bu1_pc,
   input  logic [31:0]           bu1_target,
   input  logic                  bu1_taken,
   input  logic                  btb_busy,
   input  logic                  flush_req,
   output logic                  upd_valid,
   output logic                  upd_inval,
   output logic [INDEX_BITS-1:0] upd_index,
   output logic [29-INDEX_BITS:0] upd_tag,
   output logic [31:0]           upd_target,
   output logic                  flushing,
   output logic                  flush_done
);
   localparam int PW = $clog2(QDEPTH);

   typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;
   state_t state_q, state_d;

   logic [1:0]  in_valid, in_taken, ready_w, full, nonempty, accept, push, pop;
   logic [29:0] in_pc  [2];
   logic [31:0] in_tgt [2];
   logic [29:0] pc_mem  [2][QDEPTH];
   logic [31:0] tgt_mem [2][QDEPTH];
   logic [PW:0] wr_q [2];
   logic [PW:0] rd_q [2];
   logic [PW:0] occ  [2];
   logic [PW-1:0] tail_ptr [2];
   logic        rr_q, rr_d, sel, clr, issue_ok, sweep_issue;
   logic [INDEX_BITS-1:0] cnt_q, cnt_d;
   logic        upd_valid_q, upd_inval_q, flush_done_q;
   logic [INDEX_BITS-1:0] upd_index_q;
   logic [29-INDEX_BITS:0] upd_tag_q;
   logic [31:0] upd_target_q;
   logic [29:0] head_pc;
   logic [31:0] head_tgt;
   logic        unused_pc_bits;
`ifdef BTB_UPD_MERGE_EN
   logic [1:0]  tail_hit, merge;
`endif

   assign in_valid  = {bu1_valid, bu0_valid};
   assign in_taken  = {bu1_taken, bu0_taken};
   assign in_pc[0]  = bu0_pc[31:2];
   assign in_pc[1]  = bu1_pc[31:2];
   assign in_tgt[0] = bu0_target;
   assign in_tgt[1] = bu1_target;
   assign unused_pc_bits = ^{bu0_pc[1:0], bu1_pc[1:0]};

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         occ[p]      = wr_q[p] - rd_q[p];
         full[p]     = (occ[p] == (PW+1)'(QDEPTH));
         nonempty[p] = (occ[p] != '0);
         tail_ptr[p] = wr_q[p][PW-1:0] - PW'(1);
`ifdef BTB_UPD_MERGE_EN
         tail_hit[p] = nonempty[p] &&
                       (pc_mem[p][tail_ptr[p]][INDEX_BITS-1:0] == in_pc[p][INDEX_BITS-1:0]);
`endif
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state_q <= S_RUN;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_RUN:   if (flush_req) state_d = S_FLUSH;
         S_FLUSH: if (!btb_busy) begin
            cnt_d = cnt_q + INDEX_BITS'(1);
            if (&cnt_q) state_d = S_RUN;
         end
         default: state_d = S_RUN;
      endcase
   end

   // Ready is held low during reset and whenever a sweep owns the table.
   always_comb begin
      flushing    = (state_q == S_FLUSH);
      clr         = (state_q == S_RUN) && flush_req;
      issue_ok    = (state_q == S_RUN) && !btb_busy && !flush_req;
      sweep_issue = (state_q == S_FLUSH) && !btb_busy;
      for (int p = 0; p < 2; p++) begin
`ifdef BTB_UPD_MERGE_EN
         ready_w[p] = !rst_n && (state_q == S_RUN) && (!full[p] || tail_hit[p]);
`else
         ready_w[p] = !rst_n && (state_q == S_RUN) && !full[p];
`endif
      end
   end

   assign bu0_ready = ready_w[0];
   assign bu1_ready = ready_w[1];

   always_comb begin
      sel    = (&nonempty) ? rr_q : nonempty[1];
      pop[0] = issue_ok && nonempty[0] && !sel;
      pop[1] = issue_ok && nonempty[1] && sel;
      rr_d   = rr_q;
      if (clr)                      rr_d = 1'b0;
      else if (issue_ok && &nonempty) rr_d = ~rr_q;
      head_pc  = pc_mem[sel][rd_q[sel][PW-1:0]];
      head_tgt = tgt_mem[sel][rd_q[sel][PW-1:0]];
      for (int p = 0; p < 2; p++) begin
         accept[p] = in_valid[p] && ready_w[p] && in_taken[p] && !clr;
`ifdef BTB_UPD_MERGE_EN
         // The head of a one-entry FIFO is leaving this cycle, so it cannot absorb the merge.
         merge[p] = accept[p] && tail_hit[p] && !(pop[p] && (occ[p] == (PW+1)'(1)));
         push[p]  = accept[p] && !merge[p];
`else
         push[p]  = accept[p];
`endif
      end
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (push[p]) begin
            pc_mem[p][wr_q[p][PW-1:0]]  <= in_pc[p];
            tgt_mem[p][wr_q[p][PW-1:0]] <= in_tgt[p];
         end
`ifdef BTB_UPD_MERGE_EN
         else if (merge[p]) begin
            pc_mem[p][tail_ptr[p]]  <= in_pc[p];
            tgt_mem[p][tail_ptr[p]] <= in_tgt[p];
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int p = 0; p < 2; p++) begin
            wr_q[p] <= '0;
            rd_q[p] <= '0;
         end
         rr_q         <= 1'b0;
         cnt_q        <= '0;
         upd_valid_q  <= 1'b0;
         upd_inval_q  <= 1'b0;
         upd_index_q  <= '0;
         upd_tag_q    <= '0;
         upd_target_q <= '0;
         flush_done_q <= 1'b0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (clr) begin
               wr_q[p] <= '0;
               rd_q[p] <= '0;
            end else begin
               if (push[p]) wr_q[p] <= wr_q[p] + (PW+1)'(1);
               if (pop[p])  rd_q[p] <= rd_q[p] + (PW+1)'(1);
            end
         end
         rr_q         <= rr_d;
         cnt_q        <= cnt_d;
         upd_valid_q  <= sweep_issue || (|pop);
         upd_inval_q  <= sweep_issue;
         flush_done_q <= sweep_issue && (&cnt_q);
         if (sweep_issue) begin
            upd_index_q  <= cnt_q;
            upd_tag_q    <= '0;
            upd_target_q <= '0;
         end else if (|pop) begin
            upd_index_q  <= head_pc[INDEX_BITS-1:0];
            upd_tag_q    <= head_pc[29:INDEX_BITS];
            upd_target_q <= head_tgt;
         end
      end
   end

   assign upd_valid  = upd_valid_q;
   assign upd_inval  = upd_inval_q;
   assign upd_index  = upd_index_q;
   assign upd_tag    = upd_tag_q;
   assign upd_target = upd_target_q;
   assign flush_done = flush_done_q;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb/tb_btb_update_ctrl.sv - self-checking bench for btb_update_ctrl (vector table plus write scoreboard).
module tb_btb_update_ctrl;
   logic        clk, rst_n;
   logic        bu0_valid, bu0_ready, bu0_taken, bu1_valid, bu1_ready, bu1_taken;
   logic [31:0] bu0_pc, bu0_target, bu1_pc, bu1_target;
   logic        btb_busy, flush_req;
   logic        upd_valid, upd_inval, flushing, flush_done;
   logic [7:0]  upd_index;
   logic [21:0] upd_tag;
   logic [31:0] upd_target;

   btb_update_ctrl #(.INDEX_BITS(8), .QDEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .bu0_valid(bu0_valid), .bu0_ready(bu0_ready), .bu0_pc(bu0_pc),
      .bu0_target(bu0_target), .bu0_taken(bu0_taken),
      .bu1_valid(bu1_valid), .bu1_ready(bu1_ready), .bu1_pc(bu1_pc),
      .bu1_target(bu1_target), .bu1_taken(bu1_taken),
      .btb_busy(btb_busy), .flush_req(flush_req),
      .upd_valid(upd_valid), .upd_inval(upd_inval), .upd_index(upd_index),
      .upd_tag(upd_tag), .upd_target(upd_target),
      .flushing(flushing), .flush_done(flush_done)
   );

   typedef struct {
      int          port;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        tk;
      logic [7:0]  idx;
      logic [21:0] tag;
   } vec_t;

   typedef struct {
      logic [7:0]  idx;
      logic [21:0] tag;
      logic [31:0] tgt;
      logic        inval;
      int          cyc;
   } exp_t;

   vec_t vecs [6];
   exp_t exp_q [$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   fd_count = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every observed write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst_n && flush_done === 1'b1) fd_count++;
      if (!rst_n && upd_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write unexpected idx=%h tag=%h tgt=%h inval=%b cyc=%0d",
                     upd_index, upd_tag, upd_target, upd_inval, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (upd_index !== e.idx || upd_tag !== e.tag || upd_target !== e.tgt ||
                upd_inval !== e.inval || (e.cyc >= 0 && e.cyc != cyc)) begin
               errors++;
               $display("FAIL write got idx=%h tag=%h tgt=%h inval=%b cyc=%0d want idx=%h tag=%h tgt=%h inval=%b cyc=%0d",
                        upd_index, upd_tag, upd_target, upd_inval, cyc,
                        e.idx, e.tag, e.tgt, e.inval, e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic get_ready(input int p);
      return (p == 0) ? bu0_ready : bu1_ready;
   endfunction

   function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] tgt, input int c);
      exp_t e;
      e.idx = pc[9:2];
      e.tag = pc[31:10];
      e.tgt = tgt;
      e.inval = 1'b0;
      e.cyc = c;
      return e;
   endfunction

   // Presents one request for one edge; called #1 after a rising edge.
   task automatic drive(input int p, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic tk, input logic exp_rdy);
      if (p == 0) begin
         bu0_valid = 1'b1; bu0_pc = pc; bu0_target = tgt; bu0_taken = tk;
      end else begin
         bu1_valid = 1'b1; bu1_pc = pc; bu1_target = tgt; bu1_taken = tk;
      end
      chk($sformatf("ready%0d_before_push", p), 32'(get_ready(p)), 32'(exp_rdy));
      step();
      bu0_valid = 1'b0;
      bu1_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      repeat (6) step();
      chk(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int c;
      logic done;
      exp_t e;

      vecs[0] = '{0, 32'h0000_1040, 32'h0000_2000, 1'b1, 8'h10, 22'h000004};
      vecs[1] = '{1, 32'hFFFF_FFFC, 32'h1234_5678, 1'b1, 8'hFF, 22'h3FFFFF};
      vecs[2] = '{0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 8'h00, 22'h000000};
      vecs[3] = '{0, 32'h0000_1040, 32'h0000_2000, 1'b0, 8'h00, 22'h000000};
      vecs[4] = '{1, 32'h8000_0404, 32'h0000_0004, 1'b1, 8'h01, 22'h200001};
      vecs[5] = '{1, 32'h1234_5678, 32'h0000_0008, 1'b0, 8'h00, 22'h000000};

      rst_n = 1'b1; btb_busy = 1'b0; flush_req = 1'b0;
      bu0_valid = 1'b0; bu0_pc = '0; bu0_target = '0; bu0_taken = 1'b0;
      bu1_valid = 1'b0; bu1_pc = '0; bu1_target = '0; bu1_taken = 1'b0;

      repeat (3) step();
      chk("rst_ready0", 32'(bu0_ready), 0);
      chk("rst_ready1", 32'(bu1_ready), 0);
      chk("rst_upd_valid", 32'(upd_valid), 0);
      chk("rst_upd_index", 32'(upd_index), 0);
      chk("rst_flushing", 32'(flushing), 0);
      chk("rst_flush_done", 32'(flush_done), 0);
      rst_n = 1'b0;
      step();
      chk("post_rst_ready0", 32'(bu0_ready), 1);
      chk("post_rst_ready1", 32'(bu1_ready), 1);

      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].port, vecs[i].pc, vecs[i].tgt, vecs[i].tk, 1'b1);
         if (vecs[i].tk) begin
            e.idx = vecs[i].idx; e.tag = vecs[i].tag; e.tgt = vecs[i].tgt;
            e.inval = 1'b0; e.cyc = cyc + 1;
            exp_q.push_back(e);
         end
         repeat (4) step();
         chk($sformatf("vec%0d_drain", i), exp_q.size(), 0);
         chk($sformatf("vec%0d_ready_after", i), 32'(get_ready(vecs[i].port)), 1);
      end

      btb_busy = 1'b1;
      drive(0, 32'h0000_0100, 32'h1111_0000, 1'b1, 1'b1);
      drive(1, 32'h0000_2004, 32'h2222_0000, 1'b1, 1'b1);
      drive(0, 32'h0000_03FC, 32'h1111_0001, 1'b1, 1'b1);
      drive(1, 32'h0001_0008, 32'h2222_0001, 1'b1, 1'b1);
      c = cyc;
      exp_q.push_back(mk(32'h0000_0100, 32'h1111_0000, c + 1));
      exp_q.push_back(mk(32'h0000_2004, 32'h2222_0000, c + 2));
      exp_q.push_back(mk(32'h0000_03FC, 32'h1111_0001, c + 3));
      exp_q.push_back(mk(32'h0001_0008, 32'h2222_0001, c + 4));
      btb_busy = 1'b0;
      drain("arb_drain");

      btb_busy = 1'b1;
      for (int k = 0; k < 4; k++) drive(1, 32'h0000_0500 + 32'(4 * k), 32'h0000_9000 + 32'(k), 1'b1, 1'b1);
      chk("bp_ready1_full", 32'(bu1_ready), 0);
      step();
      chk("bp_ready1_still_full", 32'(bu1_ready), 0);
      c = cyc;
      for (int k = 0; k < 4; k++) exp_q.push_back(mk(32'h0000_0500 + 32'(4 * k), 32'h0000_9000 + 32'(k), c + 1 + k));
      btb_busy = 1'b0;
      step();
      chk("bp_ready1_after_pop", 32'(bu1_ready), 1);
      drain("bp_drain");

      btb_busy = 1'b1;
      drive(0, 32'h0000_1040, 32'h0000_000A, 1'b1, 1'b1);
      drive(0, 32'h0000_1040, 32'h0000_000B, 1'b1, 1'b1);
      c = cyc;
`ifdef BTB_UPD_MERGE_EN
      exp_q.push_back(mk(32'h0000_1040, 32'h0000_000B, c + 1));
`else
      exp_q.push_back(mk(32'h0000_1040, 32'h0000_000A, c + 1));
      exp_q.push_back(mk(32'h0000_1040, 32'h0000_000B, c + 2));
`endif
      btb_busy = 1'b0;
      drain("merge_drain");

      btb_busy = 1'b1;
      drive(0, 32'h0000_0600, 32'h0000_0601, 1'b1, 1'b1);
      drive(0, 32'h0000_0604, 32'h0000_0605, 1'b1, 1'b1);
      drive(1, 32'h0000_0608, 32'h0000_0609, 1'b1, 1'b1);
      flush_req = 1'b1;
      bu0_valid = 1'b1; bu0_pc = 32'h0000_0700; bu0_target = 32'h0000_0701; bu0_taken = 1'b1;
      step();
      flush_req = 1'b0;
      btb_busy = 1'b0;
      for (int i = 0; i < 256; i++) begin
         e.idx = 8'(i); e.tag = '0; e.tgt = '0; e.inval = 1'b1; e.cyc = -1;
         exp_q.push_back(e);
      end
      done = 1'b0;
      for (int n = 0; n < 600 && !done; n++) begin
         if (flush_done === 1'b1) begin
            done = 1'b1;
            bu0_valid = 1'b0;
            chk("flushing_at_done", 32'(flushing), 0);
         end else begin
            chk("flushing_during_sweep", 32'(flushing), 1);
            chk("ready0_during_sweep", 32'(bu0_ready), 0);
            chk("ready1_during_sweep", 32'(bu1_ready), 0);
            btb_busy = (n >= 100 && n < 105);
            step();
         end
      end
      bu0_valid = 1'b0;
      btb_busy = 1'b0;
      chk("flush_done_seen", 32'(done), 1);
      repeat (4) step();
      chk("flush_done_count", fd_count, 1);
      chk("flush_drain", exp_q.size(), 0);
      exp_q.delete();

      btb_busy = 1'b1;
      drive(1, 32'h0000_0800, 32'h0000_0801, 1'b1, 1'b1);
      drive(0, 32'h0000_0804, 32'h0000_0805, 1'b1, 1'b1);
      c = cyc;
      exp_q.push_back(mk(32'h0000_0804, 32'h0000_0805, c + 1));
      exp_q.push_back(mk(32'h0000_0800, 32'h0000_0801, c + 2));
      btb_busy = 1'b0;
      drain("rr_after_flush_drain");

      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      for (int i = 0; i < 256; i++) begin
         e.idx = 8'(i); e.tag = '0; e.tgt = '0; e.inval = 1'b1; e.cyc = -1;
         exp_q.push_back(e);
      end
      repeat (10) step();
      rst_n = 1'b1;
      exp_q.delete();
      step();
      chk("midsweep_rst_flushing", 32'(flushing), 0);
      chk("midsweep_rst_ready0", 32'(bu0_ready), 0);
      rst_n = 1'b0;
      step();
      chk("midsweep_post_ready0", 32'(bu0_ready), 1);
      repeat (300) step();
      chk("midsweep_no_flush_done", fd_count, 1);

      btb_busy = 1'b1;
      drive(0, 32'h0000_0900, 32'h0000_0901, 1'b1, 1'b1);
      rst_n = 1'b1;
      step();
      rst_n = 1'b0;
      btb_busy = 1'b0;
      drain("reset_drops_queue");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
